dpr16x4_burst_reader: RTL and testbench
=======================================

DPR16X4_BURST_READER -- requirements
Module: dpr16x4_burst_reader

Interface
REQ-001 Parameter INITVAL, default 64'h0, power-up memory contents; nibble k is word k (bits 4k+3:4k).
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 WE  in  1  write enable for the memory write port.
REQ-005 WAD  in  4  write address.
REQ-006 DI  in  4  write data.
REQ-007 START  in  1  burst request; sampled only in IDLE.
REQ-008 SADDR  in  4  burst start address, captured with START.
REQ-009 LEN  in  4  burst length minus one (1..16 words), captured with START.
REQ-010 BUSY  out  1  high while a burst is in progress.
REQ-011 DO  out  4  read data word.
REQ-012 DOV  out  1  DO valid.
REQ-013 DOR  in  1  consumer ready; a word transfers on a rising edge where DOV=1 and DOR=1.
REQ-014 DONE  out  1  one-cycle pulse after the last word of a burst transfers.

Function
REQ-015 Write port SHALL store DI at MEM[WAD] on each rising CLK edge with WE=1, independent of the read FSM, at all times including during RST.
REQ-016 FSM states SHALL be IDLE and STREAM only.
REQ-017 IDLE with START=1 at edge n SHALL: capture SADDR/LEN, load DO=MEM[SADDR], set DOV=1, set BUSY=1, enter STREAM; outputs visible after edge n (latency 1).
REQ-018 START while BUSY=1 SHALL be ignored, with no effect on the current burst.
REQ-019 While DOV=1 and DOR=0, DO and DOV SHALL hold stable, including under writes to the displayed address.
REQ-020 On a transfer that is not the last, the address SHALL increment modulo 16 (15 wraps to 0), and DO SHALL load the next word in the same edge; sustained DOR=1 gives one word per cycle.
REQ-021 On a transfer of the last word (LEN+1 transfers total), the FSM SHALL set DOV=0, BUSY=0 and DONE=1 for exactly one cycle, then return to IDLE.
REQ-022 In a cycle where DONE=1, IDLE SHALL accept START, giving back-to-back bursts with one bubble cycle.
REQ-023 Read/write collision: when a word is loaded into DO at the same edge that writes its address, DO SHALL get the pre-write (old) value.
REQ-024 DO SHALL retain the last transferred value when DOV=0; consumers SHALL ignore it.

Reset
REQ-025 RST=1 at an edge SHALL force IDLE, BUSY=0, DOV=0, DO=4'h0, DONE=0, with captured address and count cleared.
REQ-026 RST SHALL NOT alter memory contents; INITVAL applies only at time zero.
REQ-027 RST asserted mid-burst SHALL abandon the burst without a DONE pulse; START in the same cycle as RST SHALL be ignored.

Structure
REQ-028 Package dpr16x4_pkg SHALL hold WIDTH=4, AW=4, DEPTH=16, and the FSM state enumeration.
REQ-029 The storage SHALL be a sub-module dpr16x4_core: a 16x4 array with synchronous write, asynchronous read, and an INITVAL parameter.
REQ-030 The burst-reader FSM, address counter and output register SHALL reside in the top level.

Verification
REQ-031 Write MEM[k]=k for k=0..15, then START with SADDR=3 and LEN=4, DOR=1 -> DO reads 3,4,5,6,7 on consecutive cycles, then DONE is high for one cycle and BUSY goes low.
REQ-032 Wrap test: START with SADDR=14 and LEN=3 -> DO reads 14,15,0,1.
REQ-033 Backpressure test: DOR=0 for 3 cycles with DO=5 while WE writes addr 5 to 4'hA -> DO holds 5 and DOV holds 1, and the next burst from addr 5 returns A.
REQ-034 Power-up test: INITVAL=64'hFEDCBA9876543210 with no writes, START with SADDR=0 and LEN=15 -> DO reads 0..F, and DONE rises after the 16th transfer.
REQ-035 RST asserted during the 2nd word of an 8-word burst -> next cycle DOV=0, BUSY=0, DO=0, no DONE, and memory still holds its written values.
REQ-036 START pulses while BUSY=1 -> the burst length and data are unchanged; START in the DONE cycle -> the new burst begins with one bubble cycle.

Source files
------------

// File: rtl/dpr16x4_pkg.sv
// Shared sizing constants, FSM state encoding and address helper
// for the 16x4 dual-port RAM burst reader.
package dpr16x4_pkg;

  localparam int WIDTH = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Addresses wrap naturally at DEPTH because AW bits cover exactly DEPTH words.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr);
    return addr + AW'(1);
  endfunction

endpackage

// File: rtl/dpr16x4_core.sv
// 16x4 storage array: synchronous write port, asynchronous read port.
// Contents power up to INITVAL and are never touched by any reset.
module dpr16x4_core
  import dpr16x4_pkg::*;
#(
  parameter logic [WIDTH*DEPTH-1:0] INITVAL = '0
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH*DEPTH-1:0] mem_q = INITVAL;
  logic [WIDTH*DEPTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[int'(waddr)*WIDTH +: WIDTH] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Reads see the array before this edge's write, giving old-data collisions.
  assign rdata = mem_q[int'(raddr)*WIDTH +: WIDTH];

endmodule

// File: rtl/dpr16x4_burst_reader.sv
// Burst reader over a 16x4 RAM: streams LEN+1 words from SADDR with a
// valid/ready handshake, then pulses DONE for one cycle.
module dpr16x4_burst_reader
  import dpr16x4_pkg::*;
#(
  parameter logic [WIDTH*DEPTH-1:0] INITVAL = 64'h0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WAD,
  input  logic [WIDTH-1:0] DI,
  input  logic             START,
  input  logic [AW-1:0]    SADDR,
  input  logic [AW-1:0]    LEN,
  output logic             BUSY,
  output logic [WIDTH-1:0] DO,
  output logic             DOV,
  input  logic             DOR,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             dov_q, dov_d;
  logic             done_q, done_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  dpr16x4_core #(
    .INITVAL(INITVAL)
  ) u_core (
    .clk  (CLK),
    .we   (WE),
    .waddr(WAD),
    .wdata(DI),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // cnt_q holds the number of words still to transfer after the one on DO.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    do_d    = do_q;
    dov_d   = dov_q;
    done_d  = 1'b0;
    rd_addr = SADDR;

    case (state_q)
      IDLE: begin
        if (START) begin
          addr_d  = SADDR;
          cnt_d   = LEN;
          do_d    = rd_data;
          dov_d   = 1'b1;
          state_d = STREAM;
        end
      end

      STREAM: begin
        rd_addr = next_addr(addr_q);
        if (DOR) begin
          if (cnt_q == '0) begin
            dov_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = rd_addr;
            cnt_d  = cnt_q - AW'(1);
            do_d   = rd_data;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      do_q    <= '0;
      dov_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      dov_q   <= dov_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q == STREAM);
  assign DO   = do_q;
  assign DOV  = dov_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_dpr16x4_burst_reader.sv
// Directed self-checking bench for dpr16x4_burst_reader: power-up contents,
// bursts, wrap, backpressure, collisions, reset mid-burst and START handling.
module tb_dpr16x4_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] wad;
  logic [3:0] di;
  logic       start;
  logic [3:0] saddr;
  logic [3:0] len;
  logic       busy;
  logic [3:0] dout;
  logic       dov;
  logic       dor;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  dpr16x4_burst_reader #(
    .INITVAL(64'hFEDCBA9876543210)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .WE   (we),
    .WAD  (wad),
    .DI   (di),
    .START(start),
    .SADDR(saddr),
    .LEN  (len),
    .BUSY (busy),
    .DO   (dout),
    .DOV  (dov),
    .DOR  (dor),
    .DONE (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] sa,
                               input logic [3:0] ln, input logic rdy, input logic w,
                               input logic [3:0] wa, input logic [3:0] wd);
    rst   = r;
    start = s;
    saddr = sa;
    len   = ln;
    dor   = rdy;
    we    = w;
    wad   = wa;
    di    = wd;
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic [3:0] d, input logic v,
                             input logic b, input logic dn);
    checkOutput({tag, ".DO"}, dout, d);
    checkOutput({tag, ".DOV"}, {3'b0, dov}, {3'b0, v});
    checkOutput({tag, ".BUSY"}, {3'b0, busy}, {3'b0, b});
    checkOutput({tag, ".DONE"}, {3'b0, done}, {3'b0, dn});
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    step();
    checkStatus("reset", 4'h0, 1'b0, 1'b0, 1'b0);

    // Power-up contents, full 16-word burst from address 0.
    applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checkStatus($sformatf("pwr%0d", k), 4'(k), 1'b1, 1'b1, 1'b0);
      step();
    end
    checkStatus("pwr_done", 4'hF, 1'b0, 1'b0, 1'b1);
    step();
    checkStatus("pwr_idle", 4'hF, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'(k), 4'(k));
      step();
    end
    we = 1'b0;

    applyStimulus(1'b0, 1'b1, 4'h3, 4'h4, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      checkStatus($sformatf("b3_%0d", k), 4'(k), 1'b1, 1'b1, 1'b0);
      step();
    end
    checkStatus("b3_done", 4'h7, 1'b0, 1'b0, 1'b1);
    step();
    checkStatus("b3_idle", 4'h7, 1'b0, 1'b0, 1'b0);

    // Address wrap 14,15,0,1.
    applyStimulus(1'b0, 1'b1, 4'hE, 4'h3, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    checkStatus("wrap0", 4'hE, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("wrap1", 4'hF, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("wrap2", 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("wrap3", 4'h1, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("wrap_done", 4'h1, 1'b0, 1'b0, 1'b1);
    step();

    // Backpressure with a write to the displayed address.
    applyStimulus(1'b0, 1'b1, 4'h5, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'hA);
    checkStatus("bp_load", 4'h5, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkStatus($sformatf("bp_hold%0d", k), 4'h5, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    checkStatus("bp_next", 4'h6, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("bp_done", 4'h6, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    checkStatus("bp_reread", 4'hA, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("bp_reread_done", 4'hA, 1'b0, 1'b0, 1'b1);
    step();

    // Load and write of the same address on one edge returns the old word.
    applyStimulus(1'b0, 1'b1, 4'h7, 4'h0, 1'b1, 1'b1, 4'h7, 4'hC);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    checkStatus("coll_old", 4'h7, 1'b1, 1'b1, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 1'b1, 4'h7, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    checkStatus("coll_new", 4'hC, 1'b1, 1'b1, 1'b0);
    step();
    step();

    // Reset during the second word of an 8-word burst, with START alongside.
    applyStimulus(1'b0, 1'b1, 4'h0, 4'h7, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    checkStatus("rst_w0", 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("rst_w1", 4'h1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h9, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    checkStatus("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    checkStatus("rst_after", 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    start = 1'b0;
    checkStatus("rst_mem", 4'hA, 1'b1, 1'b1, 1'b0);
    step();
    step();

    // START while busy is ignored; START in the DONE cycle is accepted.
    applyStimulus(1'b0, 1'b1, 4'h8, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0);
    step();
    applyStimulus(1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0);
    checkStatus("sb_w0", 4'h8, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("sb_w1", 4'h9, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("sb_w2", 4'hA, 1'b1, 1'b1, 1'b0);
    saddr = 4'h2;
    len   = 4'h0;
    step();
    checkStatus("sb_done", 4'hA, 1'b0, 1'b0, 1'b1);
    step();
    start = 1'b0;
    checkStatus("b2b_w0", 4'h2, 1'b1, 1'b1, 1'b0);
    step();
    checkStatus("b2b_done", 4'h2, 1'b0, 1'b0, 1'b1);
    step();
    checkStatus("b2b_idle", 4'h2, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
